// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: one request at a time, alignment/type check, one word-aligned memory access, formatted response.
// Latency: accept -> mem_req next cycle; response the cycle after mem_ack (min 2 cycles); error responses 1 cycle after accept.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready; mem_req is held until mem_ack or TIMEOUT.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   req_valid/req_ready          request handshake; req_we, req_type, req_addr, req_wdata are request fields
//   mem_req/mem_we/mem_addr/...  registered memory transaction, held stable while in ACCESS
//   mem_ack/mem_rdata            memory completion; rdata is valid in the ack cycle
//   rsp_valid/rsp_ready          response handshake; rsp_data = formatted load data, rsp_err = status
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TYPE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        ld_we;
  logic [2:0]  ld_type;
  logic [1:0]  ld_off;

  // Request decode (combinational on the incoming request)
  logic        illegal;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  always_comb begin
    illegal    = req_we ? (req_type > 3'd2) : (req_type > 3'd4);
    // LH/SH share encoding 001; LHU (100) only exists for loads.
    is_half    = (req_type == 3'd1) || (!req_we && req_type == 3'd4);
    is_word    = (req_type == 3'd2);
    misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    be_n       = 4'b1111;
    wdata_n    = req_wdata;
    if (req_we) begin
      if (is_word) begin
        be_n    = 4'b1111;
        wdata_n = req_wdata;
      end else if (is_half) begin
        be_n    = 4'b0011 << req_addr[1:0];
        wdata_n = {2{req_wdata[15:0]}};
      end else begin
        be_n    = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
    end
  end

  // Load formatting from the captured type and byte offset
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_type)
      3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_fmt = mem_rdata;
      3'd3:    ld_fmt = {24'd0, ld_byte};
      3'd4:    ld_fmt = {16'd0, ld_half};
      default: ld_fmt = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      ld_we     <= 1'b0;
      ld_type   <= 3'd0;
      ld_off    <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rsp_data  <= 32'd0;
      rsp_err   <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            ld_we   <= req_we;
            ld_type <= req_type;
            ld_off  <= req_addr[1:0];
            if (illegal) begin
              rsp_err  <= ERR_TYPE;
              rsp_data <= 32'd0;
              state    <= S_RESP;
            end else if (misaligned) begin
              rsp_err  <= ERR_ALIGN;
              rsp_data <= 32'd0;
              state    <= S_RESP;
            end else begin
              cnt       <= 8'd0;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem_ack) begin
            rsp_err  <= ERR_OK;
            rsp_data <= ld_we ? 32'd0 : ld_fmt;
            state    <= S_RESP;
          end else if (cnt + 8'd1 == TO_VAL) begin
            rsp_err  <= ERR_TIMEOUT;
            rsp_data <= 32'd0;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign mem_req   = (state == S_ACCESS);
  assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int hold_cnt = 0;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes from the type field (only meaningful for legal types)
  function automatic int ref_size(input logic [2:0] ty);
    if (ty == 3'd2) return 4;
    if (ty == 3'd1 || ty == 3'd4) return 2;
    return 1;
  endfunction

  // Expected response from the architectural rules; dly = wait cycles before ack
  function automatic rsp_t ref_rsp(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                                   input logic [31:0] rdata, input int dly);
    rsp_t r;
    int sz;
    logic [31:0] d;
    sz = ref_size(ty);
    r.data = 32'd0;
    if ((we && ty > 3'd2) || (!we && ty > 3'd4)) r.err = 2'b10;
    else if ((addr % sz) != 0)                   r.err = 2'b01;
    else if (dly >= TO)                          r.err = 2'b11;
    else begin
      r.err = 2'b00;
      if (!we) begin
        d = rdata >> ((addr % 4) * 8);
        if (sz == 1) begin
          d = d & 32'hFF;
          if (ty == 3'd0 && d >= 32'd128) d = d - 32'd256;
        end else if (sz == 2) begin
          d = d & 32'hFFFF;
          if (ty == 3'd1 && d >= 32'd32768) d = d - 32'd65536;
        end
        r.data = d;
      end
    end
    return r;
  endfunction

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_be",    32'(mem_be),    32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // Issue one request and play the memory side; dly >= TO means no ack (timeout)
  task automatic do_req(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly, input int hold);
    rsp_t e;
    int sz;
    logic [31:0] exp_be, exp_wd;
    e  = ref_rsp(we, ty, addr, rd, dly);
    sz = ref_size(ty);
    wait_ready();
    if (!req_ready) return;
    exp_q.push_back(e);
    hold_cnt  = hold;
    req_valid = 1'b1;
    req_we    = we;
    req_type  = ty;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (e.err == 2'b01 || e.err == 2'b10) begin
      chk("err_no_mem_req", 32'(mem_req), 32'd0);
      chk("err_rsp_valid",  32'(rsp_valid), 32'd1);
      return;
    end
    exp_be = we ? (((32'd1 << sz) - 32'd1) << (addr % 4)) : 32'hF;
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("mem_be", 32'(mem_be), exp_be);
    if (we) begin
      exp_wd = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
               (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      chk("mem_wdata", mem_wdata, exp_wd);
    end
    for (int i = 0; i < TO; i++) begin
      chk("mem_req_hi", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      mem_ack   = (i == dly);
      mem_rdata = (i == dly) ? rd : $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      if (i == dly) break;
    end
    chk("mem_req_drop", 32'(mem_req), 32'd0);
    chk("rsp_valid_after_mem", 32'(rsp_valid), 32'd1);
    if (dly >= TO) begin
      // late ack after timeout must be ignored
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Response monitor: random backpressure, stability check, scoreboard pop
  initial begin
    rsp_t got, prev, e;
    logic held;
    held = 1'b0;
    prev = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        got = {rsp_err, rsp_data};
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (held) begin
          chk("rsp_data_stable", got.data, prev.data);
          chk("rsp_err_stable", 32'(got.err), 32'(prev.err));
        end
        if (hold_cnt > 0) begin
          rsp_ready = 1'b0;
          hold_cnt--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (rsp_ready) begin
          held = 1'b0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: got err %0d data 0x%08h with no response expected", got.err, got.data);
          end else begin
            e = exp_q.pop_front();
            n_cmp--;
            chk("rsp_data", got.data, e.data);
            chk("rsp_err", 32'(got.err), 32'(e.err));
          end
        end else begin
          held = 1'b1;
          prev = got;
        end
      end else begin
        if (held) chk("rsp_valid_dropped", 32'(rsp_valid), 32'd1);
        held = 1'b0;
        rsp_ready = $urandom_range(0, 1) != 0;
      end
    end
  end

  initial begin
    logic        we;
    logic [2:0]  ty;
    logic [31:0] a;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_req(1'b0, 3'd0, 32'h103, 32'd0,        32'h80FF_1234, 0, 0);  // LB
    do_req(1'b0, 3'd4, 32'h22,  32'd0,        32'h9ABC_0000, 3, 0);  // LHU, 3 wait cycles
    do_req(1'b1, 3'd1, 32'h46,  32'h1234_BEEF, 32'h0,        0, 0);  // SH
    do_req(1'b0, 3'd2, 32'h5,   32'd0,        32'h0,         0, 0);  // LW misaligned
    do_req(1'b0, 3'd6, 32'h7,   32'd0,        32'h0,         0, 4);  // illegal + misaligned, backpressure
    do_req(1'b0, 3'd2, 32'h40,  32'd0,        32'h0,        99, 0);  // timeout + late ack
    do_req(1'b0, 3'd2, 32'h44,  32'd0,        32'hCAFE_F00D, TO - 1, 0); // ack on timeout cycle
    do_req(1'b1, 3'd0, 32'h13,  32'h0000_00A5, 32'h0,        1, 0);  // SB lane 3
    do_req(1'b1, 3'd5, 32'h0,   32'd0,        32'h0,         0, 0);  // illegal store type
    drain();

    // Reset during ACCESS: no response, outputs return to reset values
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    repeat (3) @(negedge clk);
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'd2, 32'h8, 32'd0, 32'h1357_9BDF, 1, 0);
    drain();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      we = $urandom_range(0, 1) != 0;
      ty = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, we ? 2 : 4));
      a  = $urandom;
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      do_req(we, ty, a, $urandom, $urandom, $urandom_range(0, TO + 1), 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "global timeout");
  end
endmodule
